// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave.
// Programmable wait states, two-cycle ERROR, little-endian byte lanes.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned IW    = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [1:0]              size_q, size_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem_q [DEPTH];

    logic                    req_err;
    logic                    accept;
    logic                    commit;
    logic [IW-1:0]           wr_idx;
    logic [31:0]             wr_word_d;
    logic                    rd_live;
    logic                    rd_wait;
    logic [IW-1:0]           rd_idx;
    logic [31:0]             rd_word;
    state_t                  tgt;
    logic                    unused_ok;

    assign unused_ok = ^{HTRANS[0], HBURST};
    assign HRDATA    = rdata_q;

    // Merge write data into the old word on the lanes HSIZE/addr select.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_w,
        input logic [31:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  lane
    );
        logic [3:0]  be;
        logic [31:0] res;
        case (sz)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Address-phase decode: legality, acceptance and the write commit.
    always_comb begin
        req_err = (HADDR[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH])
               || (HSIZE > 3'b010)
               || ((HSIZE == 3'b001) && HADDR[0])
               || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
        accept  = HSEL && HREADY && HTRANS[1]
               && ((state_q == ST_IDLE) || (state_q == ST_DATA)
                   || (state_q == ST_ERR2));
        commit  = (state_q == ST_DATA) && HREADY && write_q;
        wr_idx  = addr_q[ADDR_WIDTH-1:2];
        wr_word_d = merge_word(mem_q[wr_idx], HWDATA, size_q, addr_q[1:0]);
        if (req_err) begin
            tgt = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
            tgt = ST_DATA;
        end else begin
            tgt = ST_WAIT;
        end
    end

    // Read capture on entry to ST_DATA, forwarding a same-edge write.
    always_comb begin
        rd_live = accept && !req_err && (WAIT_STATES == 0) && !HWRITE;
        rd_wait = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !write_q;
        rd_idx  = rd_live ? HADDR[ADDR_WIDTH-1:2] : addr_q[ADDR_WIDTH-1:2];
        if (commit && (wr_idx == rd_idx)) begin
            rd_word = wr_word_d;
        end else begin
            rd_word = mem_q[rd_idx];
        end
        rdata_d = (rd_live || rd_wait) ? rd_word : rdata_q;
    end

    // Next-state, pending-transfer registers and bus responses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        if (accept) begin
            addr_d  = HADDR[ADDR_WIDTH-1:0];
            write_d = HWRITE;
            size_d  = HSIZE[1:0];
            cnt_d   = WAIT_LOAD;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = tgt;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DATA: begin
                if (HREADY) state_d = accept ? tgt : ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
                if (HREADY) state_d = accept ? tgt : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and read-data registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (commit) mem_q[wr_idx] <= wr_word_d;
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave.
// Two instances: zero wait states and two wait states.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  hsel;
    logic [1:0]  hwrite;
    logic [1:0]  hrdyo;
    logic [1:0]  hresp;
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic [2:0]  hburst [2];
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];

    exp_t        sb0 [$];
    exp_t        sb1 [$];
    exp_t        cur [2];
    bit          in_dp [2];
    int          cyc [2];
    logic [31:0] model [2][256];
    int          checks = 0;
    int          failures = 0;
    bit          mon_off = 1'b1;

    always #5 clk = ~clk;

    ahb_sram_slave #(
        .ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)
    ) u0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]),
        .HADDR(haddr[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]),
        .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hrdyo[0]), .HREADYOUT(hrdyo[0]), .HRESP(hresp[0]),
        .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(
        .ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)
    ) u1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]),
        .HADDR(haddr[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]),
        .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hrdyo[1]), .HREADYOUT(hrdyo[1]), .HRESP(hresp[1]),
        .HRDATA(hrdata[1])
    );

    task automatic chk(input string nm, input int u,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d act=%h exp=%h t=%0t",
                     nm, u, act, exp, $time);
        end
    endtask

    // Legal only inside the 1 KiB window and naturally aligned.
    function automatic bit is_err(input logic [2:0] sz,
                                  input logic [31:0] a);
        int nb;
        if (sz > 3'd2) return 1'b1;
        nb = 1 << sz;
        return (a >= 32'd1024) || ((a % nb) != 0);
    endfunction

    task automatic issue(input int u, input bit sel,
                         input logic [1:0] tr, input bit wr,
                         input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        int   nb;
        int   n;
        logic r;
        if (sel && tr[1]) begin
            e.err  = is_err(sz, a);
            e.rd   = !wr;
            e.data = 32'd0;
            if (!e.err) begin
                if (wr) begin
                    nb = 1 << sz;
                    for (int j = 0; j < nb; j++) begin
                        int lane;
                        lane = int'(a[1:0]) + j;
                        model[u][a[9:2]][8*lane +: 8] = wd[8*lane +: 8];
                    end
                end else begin
                    e.data = model[u][a[9:2]];
                end
            end
            if (u == 0) sb0.push_back(e);
            else sb1.push_back(e);
        end
        hsel[u]   = sel;
        htrans[u] = tr;
        hwrite[u] = wr;
        hsize[u]  = sz;
        haddr[u]  = a;
        n = 0;
        do begin
            @(negedge clk);
            r = hrdyo[u];
            @(posedge clk);
            n++;
        end while (!r && n < 64);
        if (!r) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout u%0d act=stuck exp=ready", u);
        end
        #1;
        hwdata[u] = wd;
    endtask

    task automatic wr(input int u, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
        issue(u, 1'b1, T_NSEQ, 1'b1, sz, a, d);
    endtask

    task automatic rd(input int u, input logic [31:0] a);
        issue(u, 1'b1, T_NSEQ, 1'b0, 3'd2, a, $urandom);
    endtask

    task automatic idle(input int u);
        issue(u, 1'b0, T_IDLE, 1'b0, 3'd2, 32'd0, 32'd0);
    endtask

    // Per-unit data-phase tracker: pops on accept, checks every cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int ws;
                bit done;
                ws = (k == 0) ? 0 : 2;
                done = 1'b0;
                if (!rst_n || mon_off) begin
                    in_dp[k] = 1'b0;
                end else begin
                    if (in_dp[k]) begin
                        cyc[k]++;
                        e = cur[k];
                        if (e.err) begin
                            chk("err_phase", k,
                                32'({hresp[k], hrdyo[k]}),
                                32'({1'b1, cyc[k] >= 2}));
                            done = hrdyo[k] || (cyc[k] >= 2);
                        end else begin
                            chk("okay_phase", k,
                                32'({hresp[k], hrdyo[k]}),
                                32'({1'b0, cyc[k] >= ws + 1}));
                            done = hrdyo[k] || (cyc[k] >= ws + 1);
                            if (hrdyo[k] && e.rd)
                                chk("rdata", k, hrdata[k], e.data);
                        end
                        if (done) in_dp[k] = 1'b0;
                    end else begin
                        chk("idle_okay", k,
                            32'({hresp[k], hrdyo[k]}), 32'd1);
                    end
                    if (!in_dp[k] && hsel[k] && hrdyo[k]
                        && htrans[k][1]) begin
                        if ((k == 0 && sb0.size() == 0)
                            || (k == 1 && sb1.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_empty u%0d act=0 exp=1", k);
                        end else begin
                            cur[k] = (k == 0) ? sb0.pop_front()
                                              : sb1.pop_front();
                            in_dp[k] = 1'b1;
                            cyc[k] = 0;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        int          szr;
        hsel   = 2'b00;
        hwrite = 2'b00;
        for (int u = 0; u < 2; u++) begin
            htrans[u] = T_IDLE;
            hsize[u]  = 3'd2;
            hburst[u] = 3'd0;
            haddr[u]  = 32'd0;
            hwdata[u] = 32'd0;
            in_dp[u]  = 1'b0;
            cyc[u]    = 0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_hreadyout", u, 32'(hrdyo[u]), 32'd1);
            chk("rst_hresp", u, 32'(hresp[u]), 32'd0);
            chk("rst_hrdata", u, hrdata[u], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_off = 1'b0;

        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 256; w++)
                wr(u, 3'd2, 32'(w * 4), $urandom);
            idle(u);

            wr(u, 3'd2, 32'h10, 32'hDEADBEEF);
            rd(u, 32'h10);
            wr(u, 3'd2, 32'h10, 32'h11223344);
            wr(u, 3'd0, 32'h13, 32'hAA00_0000);
            rd(u, 32'h10);
            wr(u, 3'd1, 32'h12, 32'h5566_0000);
            rd(u, 32'h10);
            idle(u);

            wr(u, 3'd2, 32'h12, 32'hFFFF_FFFF);
            wr(u, 3'd2, 32'h400, 32'hFFFF_FFFF);
            wr(u, 3'd3, 32'h10, 32'hFFFF_FFFF);
            wr(u, 3'd1, 32'h11, 32'hFFFF_FFFF);
            rd(u, 32'h12);
            rd(u, 32'h10);
            rd(u, 32'h0);
            idle(u);

            hburst[u] = 3'b011;
            issue(u, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'hA0A0_0020);
            issue(u, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h24, 32'hA1A1_0024);
            issue(u, 1'b1, T_BUSY, 1'b1, 3'd2, 32'h28, 32'h0);
            issue(u, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h28, 32'hA2A2_0028);
            issue(u, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h2C, 32'hA3A3_002C);
            issue(u, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
            issue(u, 1'b1, T_SEQ,  1'b0, 3'd2, 32'h24, 32'h0);
            issue(u, 1'b1, T_SEQ,  1'b0, 3'd2, 32'h28, 32'h0);
            issue(u, 1'b1, T_SEQ,  1'b0, 3'd2, 32'h2C, 32'h0);
            hburst[u] = 3'b000;
            idle(u);

            for (int i = 0; i < 300; i++) begin
                szr = $urandom_range(0, 9);
                if (szr < 3) sz = 3'd0;
                else if (szr < 6) sz = 3'd1;
                else if (szr < 9) sz = 3'd2;
                else sz = 3'($urandom_range(3, 7));
                if ($urandom_range(0, 19) == 0) a = $urandom;
                else a = {22'd0, 10'($urandom)};
                hburst[u] = 3'($urandom_range(0, 7));
                issue(u, $urandom_range(0, 9) != 0,
                      2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), sz, a, $urandom);
            end
            idle(u);
        end

        wr(1, 3'd2, 32'h40, 32'h1234_5678);
        idle(1);
        repeat (2) @(posedge clk);
        #1;
        mon_off   = 1'b1;
        hsel[1]   = 1'b1;
        htrans[1] = T_NSEQ;
        hwrite[1] = 1'b1;
        hsize[1]  = 3'd2;
        haddr[1]  = 32'h40;
        @(posedge clk);
        #1;
        hsel[1]   = 1'b0;
        htrans[1] = T_IDLE;
        hwdata[1] = 32'hCAFE_F00D;
        chk("wait_low", 1, 32'(hrdyo[1]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_hreadyout", 1, 32'(hrdyo[1]), 32'd1);
        chk("rstmid_hresp", 1, 32'(hresp[1]), 32'd0);
        chk("rstmid_hrdata", 1, hrdata[1], 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_off = 1'b0;
        rd(1, 32'h40);
        idle(1);
        rd(0, 32'h10);
        idle(0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drain", 0, 32'(sb0.size() + sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
